// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler
//   Four-way intersection phase scheduler. One approach owns the phase at a
//   time and walks GREEN -> YELLOW -> ALL_RED before the next approach is
//   chosen. Approach index: 0=South, 1=West, 2=North, 3=East.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous reset, active-high
//   Emergency[3:0] emergency vehicle present per approach (level)
//   Jam[3:0]     queue jammed per approach (level)
//   Empty[3:0]   no vehicles waiting per approach (level)
//   South_road, West_road, North_road, East_road [2:0]
//                light {R,Y,G}: 100 red, 010 yellow, 001 green
//   active_road[1:0] approach currently owning the phase
//   phase[1:0]   00 ALL_RED, 01 GREEN, 10 YELLOW
//
// state      | meaning
// ST_ALL_RED | all roads red; clearance, next approach chosen on the exit cycle
// ST_GREEN   | active approach green; emergency on it freezes the timer
// ST_YELLOW  | active approach yellow; always runs to completion
module traffic_phase_scheduler #(
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 8,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int CNT_W     = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] Emergency,
    input  logic [3:0] Jam,
    input  logic [3:0] Empty,
    output logic [2:0] South_road,
    output logic [2:0] West_road,
    output logic [2:0] North_road,
    output logic [2:0] East_road,
    output logic [1:0] active_road,
    output logic [1:0] phase
);

    typedef enum logic [1:0] {
        ST_ALL_RED = 2'b00,
        ST_GREEN   = 2'b01,
        ST_YELLOW  = 2'b10
    } state_t;

    localparam logic [2:0] LIGHT_RED = 3'b100;
    localparam logic [2:0] LIGHT_YEL = 3'b010;
    localparam logic [2:0] LIGHT_GRN = 3'b001;

    localparam logic [CNT_W-1:0] GREEN_MIN_LAST = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GREEN_MAX_LAST = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST    = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST    = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] TIMER_SAT      = '1;

    state_t           state_q, state_d;
    logic [1:0]       cur_q, cur_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [3:0][2:0]  roads_q, roads_d;
    logic             hold_timer;
    logic [2:0]       light;

    // Emergency wins by lowest index. Otherwise scan cur+1, cur+2, cur+3, cur
    // for the first non-empty approach; cur itself comes last so a lone busy
    // approach keeps the green. With everything empty, rotate plainly.
    function automatic logic [1:0] pick_next(input logic [1:0] cur,
                                             input logic [3:0] emg,
                                             input logic [3:0] empty);
        logic [1:0] sel;
        logic [1:0] cand;
        logic       found;
        sel   = cur + 2'd1;
        found = 1'b0;
        if (emg != 4'b0000) begin
            for (int i = 3; i >= 0; i--) begin
                if (emg[i]) begin
                    sel = 2'(i);
                end
            end
        end else begin
            for (int i = 1; i <= 4; i++) begin
                cand = cur + 2'(i);
                if (!found && !empty[cand]) begin
                    sel   = cand;
                    found = 1'b1;
                end
            end
        end
        return sel;
    endfunction

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        timer_d    = timer_q;
        hold_timer = 1'b0;

        case (state_q)
            ST_ALL_RED: begin
                if (timer_q >= ALLRED_LAST) begin
                    state_d = ST_GREEN;
                    cur_d   = pick_next(cur_q, Emergency, Empty);
                end
            end
            ST_GREEN: begin
                if (Emergency[cur_q]) begin
                    hold_timer = 1'b1;
                end else if (Emergency != 4'b0000) begin
                    state_d = ST_YELLOW;
                end else if (timer_q == GREEN_MAX_LAST) begin
                    state_d = ST_YELLOW;
                end else if ((timer_q >= GREEN_MIN_LAST) && !Jam[cur_q]) begin
                    state_d = ST_YELLOW;
                end
            end
            ST_YELLOW: begin
                if (timer_q >= YELLOW_LAST) begin
                    state_d = ST_ALL_RED;
                end
            end
            default: begin
                state_d = ST_ALL_RED;
            end
        endcase

        if (state_d != state_q) begin
            timer_d = '0;
        end else if (!hold_timer && (timer_q != TIMER_SAT)) begin
            timer_d = timer_q + CNT_W'(1);
        end

        // Lights are decoded from the next state so the road buses come
        // straight out of flops and only the owning approach can leave red.
        case (state_d)
            ST_GREEN:  light = LIGHT_GRN;
            ST_YELLOW: light = LIGHT_YEL;
            default:   light = LIGHT_RED;
        endcase

        for (int i = 0; i < 4; i++) begin
            roads_d[i] = (cur_d == 2'(i)) ? light : LIGHT_RED;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ALL_RED;
            cur_q   <= 2'd3;
            timer_q <= '0;
            roads_q <= {4{LIGHT_RED}};
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            timer_q <= timer_d;
            roads_q <= roads_d;
        end
    end

    assign South_road  = roads_q[0];
    assign West_road   = roads_q[1];
    assign North_road  = roads_q[2];
    assign East_road   = roads_q[3];
    assign active_road = cur_q;
    assign phase       = state_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Testbench for traffic_phase_scheduler: directed scenarios with literal
// expectations plus a randomized run checked each cycle against a
// behavioural model of the phase rules.
module tb_traffic_phase_scheduler;

    localparam int GREEN_MIN = 4;
    localparam int GREEN_MAX = 8;
    localparam int YELLOW_T  = 2;
    localparam int ALLRED_T  = 1;

    logic       clk;
    logic       rst;
    logic [3:0] Emergency;
    logic [3:0] Jam;
    logic [3:0] Empty;
    logic [2:0] South_road;
    logic [2:0] West_road;
    logic [2:0] North_road;
    logic [2:0] East_road;
    logic [1:0] active_road;
    logic [1:0] phase;

    int errors = 0;
    int checks = 0;

    traffic_phase_scheduler #(
        .GREEN_MIN(GREEN_MIN),
        .GREEN_MAX(GREEN_MAX),
        .YELLOW_T (YELLOW_T),
        .ALLRED_T (ALLRED_T),
        .CNT_W    (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .Emergency  (Emergency),
        .Jam        (Jam),
        .Empty      (Empty),
        .South_road (South_road),
        .West_road  (West_road),
        .North_road (North_road),
        .East_road  (East_road),
        .active_road(active_road),
        .phase      (phase)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    // m_ph: 0 all-red, 1 green, 2 yellow. m_age: cycles counted in the phase
    // (green time does not advance while the owner has an emergency).
    int m_ph    = 0;
    int m_cur   = 3;
    int m_age   = 0;
    bit m_valid = 1'b0;

    function automatic int model_next(input int cur, input logic [3:0] emg,
                                      input logic [3:0] emp);
        if (emg != 4'b0000) begin
            for (int i = 0; i < 4; i++) if (emg[i]) return i;
        end
        for (int k = 1; k <= 4; k++) if (!emp[(cur + k) % 4]) return (cur + k) % 4;
        return (cur + 1) % 4;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_ph    <= 0;
            m_cur   <= 3;
            m_age   <= 0;
            m_valid <= 1'b1;
        end else if (m_ph == 0) begin
            if (m_age + 1 >= ALLRED_T) begin
                m_ph  <= 1;
                m_age <= 0;
                m_cur <= model_next(m_cur, Emergency, Empty);
            end else begin
                m_age <= m_age + 1;
            end
        end else if (m_ph == 1) begin
            if (Emergency[m_cur]) begin
                m_age <= m_age;
            end else if (Emergency != 4'b0000 || m_age + 1 == GREEN_MAX ||
                         (m_age + 1 >= GREEN_MIN && !Jam[m_cur])) begin
                m_ph  <= 2;
                m_age <= 0;
            end else begin
                m_age <= m_age + 1;
            end
        end else begin
            if (m_age + 1 >= YELLOW_T) begin
                m_ph  <= 0;
                m_age <= 0;
            end else begin
                m_age <= m_age + 1;
            end
        end
    end

    function automatic logic [2:0] road_of(input int k);
        case (k)
            0:       return South_road;
            1:       return West_road;
            2:       return North_road;
            default: return East_road;
        endcase
    endfunction

    // Per-cycle compare against the model.
    initial begin
        forever begin
            logic [2:0] er [4];
            logic [2:0] lt;
            int         lit;
            @(negedge clk);
            if (m_valid) begin
                lt = (m_ph == 1) ? 3'b001 : (m_ph == 2) ? 3'b010 : 3'b100;
                for (int k = 0; k < 4; k++) er[k] = (k == m_cur) ? lt : 3'b100;
                checks++;
                if ({South_road, West_road, North_road, East_road, active_road, phase} !==
                    {er[0], er[1], er[2], er[3], 2'(m_cur), 2'(m_ph)}) begin
                    errors++;
                    $display("FAIL model t=%0t: got S=%b W=%b N=%b E=%b act=%0d ph=%b, need S=%b W=%b N=%b E=%b act=%0d ph=%0d",
                             $time, South_road, West_road, North_road, East_road, active_road, phase,
                             er[0], er[1], er[2], er[3], m_cur, m_ph);
                end
                lit = 0;
                for (int k = 0; k < 4; k++) if (road_of(k) != 3'b100) lit++;
                checks++;
                if (lit > 1) begin
                    errors++;
                    $display("FAIL one_lit t=%0t: got %0d non-red roads, need at most 1", $time, lit);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check_lit(input string name, input logic [2:0] s, input logic [2:0] w,
                             input logic [2:0] n, input logic [2:0] e,
                             input logic [1:0] act, input logic [1:0] ph);
        checks++;
        if ({South_road, West_road, North_road, East_road, active_road, phase} !==
            {s, w, n, e, act, ph}) begin
            errors++;
            $display("FAIL %s t=%0t: got S=%b W=%b N=%b E=%b act=%0d ph=%b, need S=%b W=%b N=%b E=%b act=%0d ph=%b",
                     name, $time, South_road, West_road, North_road, East_road, active_road, phase,
                     s, w, n, e, act, ph);
        end
    endtask

    task automatic check_road(input string name, input int k, input logic [2:0] val);
        checks++;
        if (road_of(k) !== val) begin
            errors++;
            $display("FAIL %s t=%0t: road %0d got %b, need %b", name, $time, k, road_of(k), val);
        end
    endtask

    task automatic wait_road(input string name, input int k, input logic [2:0] val);
        int n;
        n = 0;
        while (road_of(k) !== val && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (road_of(k) !== val) begin
            errors++;
            $display("FAIL %s t=%0t: timeout, road %0d got %b, need %b", name, $time, k, road_of(k), val);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        Emergency = 4'b0000;
        Jam = 4'b0000;
        Empty = 4'b0000;
        repeat (3) @(negedge clk);
        check_lit("reset_state", 3'b100, 3'b100, 3'b100, 3'b100, 2'd3, 2'b00);
        rst = 1'b0;

        // Unloaded rotation: 4 green, 2 yellow, 1 all-red per approach.
        for (int t = 1; t <= 29; t++) begin
            logic [2:0] r [4];
            logic [2:0] lt;
            logic [1:0] ph;
            int a;
            int w;
            a = ((t - 1) / 7) % 4;
            w = (t - 1) % 7;
            if (w < 4) begin
                lt = 3'b001; ph = 2'b01;
            end else if (w < 6) begin
                lt = 3'b010; ph = 2'b10;
            end else begin
                lt = 3'b100; ph = 2'b00;
            end
            for (int k = 0; k < 4; k++) r[k] = 3'b100;
            r[a] = lt;
            @(negedge clk);
            check_lit("rotation", r[0], r[1], r[2], r[3], 2'(a), ph);
        end

        // North empty: skipped, S -> W -> E.
        Empty = 4'b0100;
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            check_road("north_skipped", 2, 3'b100);
            if (k == 14) check_lit("east_after_west", 3'b100, 3'b100, 3'b100, 3'b001, 2'd3, 2'b01);
        end
        Empty = 4'b0000;

        // West jammed: 8 green cycles.
        Jam = 4'b0010;
        wait_road("jam_wait", 1, 3'b001);
        for (int k = 2; k <= 8; k++) begin
            @(negedge clk);
            check_road("jam_green", 1, 3'b001);
        end
        @(negedge clk);
        check_road("jam_yellow", 1, 3'b010);

        // Jam dropped at green cycle 5: yellow next.
        wait_road("jam_wait2", 1, 3'b001);
        repeat (4) @(negedge clk);
        check_road("jam_g5", 1, 3'b001);
        Jam = 4'b0000;
        @(negedge clk);
        check_road("jam_drop_yellow", 1, 3'b010);

        // Emergency on North during West green.
        wait_road("emg_wait", 1, 3'b001);
        Emergency = 4'b0100;
        @(negedge clk);
        check_lit("emg_w_y1", 3'b100, 3'b010, 3'b100, 3'b100, 2'd1, 2'b10);
        @(negedge clk);
        check_lit("emg_w_y2", 3'b100, 3'b010, 3'b100, 3'b100, 2'd1, 2'b10);
        @(negedge clk);
        check_lit("emg_allred", 3'b100, 3'b100, 3'b100, 3'b100, 2'd1, 2'b00);
        @(negedge clk);
        check_lit("emg_n_green", 3'b100, 3'b100, 3'b001, 3'b100, 2'd2, 2'b01);
        repeat (10) begin
            @(negedge clk);
            check_road("emg_hold", 2, 3'b001);
        end
        Emergency = 4'b0000;
        repeat (3) begin
            @(negedge clk);
            check_road("emg_resume", 2, 3'b001);
        end
        @(negedge clk);
        check_road("emg_n_yellow", 2, 3'b010);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check_lit("emg_then_east", 3'b100, 3'b100, 3'b100, 3'b001, 2'd3, 2'b01);

        // Emergency elsewhere while North green; lowest index wins next.
        wait_road("pre_wait", 2, 3'b001);
        Emergency = 4'b0001;
        @(negedge clk);
        check_lit("pre_n_y1", 3'b100, 3'b100, 3'b010, 3'b100, 2'd2, 2'b10);
        Emergency = 4'b0101;
        @(negedge clk);
        check_lit("pre_n_y2", 3'b100, 3'b100, 3'b010, 3'b100, 2'd2, 2'b10);
        @(negedge clk);
        check_lit("pre_allred", 3'b100, 3'b100, 3'b100, 3'b100, 2'd2, 2'b00);
        @(negedge clk);
        check_lit("pre_south", 3'b001, 3'b100, 3'b100, 3'b100, 2'd0, 2'b01);
        repeat (5) begin
            @(negedge clk);
            check_road("pre_south_hold", 0, 3'b001);
        end
        Emergency = 4'b0000;

        // Reset during East yellow.
        wait_road("rst_wait", 3, 3'b010);
        rst = 1'b1;
        @(negedge clk);
        check_lit("rst_mid", 3'b100, 3'b100, 3'b100, 3'b100, 2'd3, 2'b00);
        rst = 1'b0;
        @(negedge clk);
        check_lit("rst_south", 3'b001, 3'b100, 3'b100, 3'b100, 2'd0, 2'b01);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 3))
                    0, 1:    Emergency = 4'b0000;
                    2:       Emergency = 4'b0001 << $urandom_range(0, 3);
                    default: Emergency = 4'($urandom);
                endcase
            end
            if ($urandom_range(0, 9) == 0) Jam = 4'($urandom);
            if ($urandom_range(0, 9) == 0) Empty = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom);
        end
        rst = 1'b0;
        Emergency = 4'b0000;
        Jam = 4'b0000;
        Empty = 4'b0000;
        @(negedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
